text_video_gen2: RTL and testbench

Parametrised text-mode pixel generator for 40- and 80-column displays; successor to the fixed 40-column text path. It sits between the display timing generator and the VGA pins, fetching characters and colours from an external dual-port video RAM and glyphs from the character RAM. It adds runtime 40/80-column mode, a programmable 16-entry 12-bit palette, a border colour and a blinking cursor. All timing inputs pass through a fixed-latency pipeline to registered VGA outputs.

---
 rtl/text_video_gen2_if.sv | 13 +
 rtl/text_video_gen2.sv | 248 ++++++++++++++++++++++++
 tb/tb_text_video_gen2.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_video_gen2_if.sv
// Register write bus for text_video_gen2.
//   reg_addr   : register select (0..7)
//   reg_wrdata : write data
//   reg_wren   : write strobe, one clock per write
// master drives the bus (CPU side), slave receives it (text_video_gen2).
interface text_video_gen2_if;
  logic [2:0] reg_addr;
  logic [7:0] reg_wrdata;
  logic       reg_wren;

  modport master (output reg_addr, output reg_wrdata, output reg_wren);
  modport slave  (input  reg_addr, input  reg_wrdata, input  reg_wren);
endinterface

// File: rtl/text_video_gen2.sv
// text_video_gen2 - 40/80-column text-mode pixel generator.
//
// Sits between the display timing generator and the VGA pins. It fetches
// character/colour words from an external video RAM and glyph rows from the
// character RAM, then maps pixels through a 16-entry 12-bit palette. Three
// pipeline stages plus an output register give a fixed 3-clock latency from
// hpos/vpos/syncs to the vga_* outputs.
//
// Ports:
//   clk, reset          pixel clock; asynchronous active-low reset
//   hpos, vpos          position from the timing generator
//   hsync, vsync, blank timing strobes aligned with hpos/vpos
//   reg_bus             register write bus (text_video_gen2_if.slave)
//   vram_addr           video RAM word address (combinational, stage 0)
//   vram_rddata         {fg[15:12], bg[11:8], char[7:0]}, one clock later
//   charram_addr        {char, glyph line} (combinational, stage 1)
//   charram_data        glyph row one clock later, bit 7 = leftmost pixel
//   vga_r/g/b           registered colour
//   vga_hsync/vsync     syncs delayed by 3 clocks
//
// Build option: define TEXT_CURSOR_EN to include the blinking cursor
// (CUR_COL/CUR_ROW registers, CTRL bit2 and the frame blink counter).
module text_video_gen2 #(
  parameter int H_BORDER = 32,
  parameter int V_BORDER = 20,
  parameter int ROWS     = 25,
  parameter int HPOS_W   = 10,
  parameter int VPOS_W   = 9,
  parameter int VRAM_AW  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [HPOS_W-1:0]  hpos,
  input  logic [VPOS_W-1:0]  vpos,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank,
  text_video_gen2_if.slave   reg_bus,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [15:0]        vram_rddata,
  output logic [10:0]        charram_addr,
  input  logic [7:0]         charram_data,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync
);

  localparam logic [HPOS_W:0] H_START = (HPOS_W+1)'(H_BORDER);
  localparam logic [HPOS_W:0] H_STOP  = (HPOS_W+1)'(H_BORDER + 640);
  localparam logic [VPOS_W:0] V_START = (VPOS_W+1)'(V_BORDER);
  localparam logic [VPOS_W:0] V_STOP  = (VPOS_W+1)'(V_BORDER + ROWS * 8);

  // ---------------- register file ----------------
  logic        ctrl_mode80, ctrl_text_en;
  logic [3:0]  border_idx, pal_idx;
  logic [7:0]  pal_lo;
  logic [11:0] palette [16];
`ifdef TEXT_CURSOR_EN
  logic        ctrl_cursor;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
`endif

  // NOTE: state is written with <= so every flop samples the pre-edge value;
  // the palette is a small flop array, so it takes an async reset like any
  // other register (a real RAM macro could not be reset this way).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_mode80  <= 1'b0;
      ctrl_text_en <= 1'b1;
      border_idx   <= '0;
      pal_idx      <= '0;
      pal_lo       <= '0;
      for (int i = 0; i < 16; i++) palette[i] <= {3{4'(i)}};
`ifdef TEXT_CURSOR_EN
      ctrl_cursor  <= 1'b0;
      cur_col      <= '0;
      cur_row      <= '0;
`endif
    end else if (reg_bus.reg_wren) begin
      case (reg_bus.reg_addr)
        3'd0: begin
          ctrl_mode80  <= reg_bus.reg_wrdata[0];
          ctrl_text_en <= reg_bus.reg_wrdata[1];
`ifdef TEXT_CURSOR_EN
          ctrl_cursor  <= reg_bus.reg_wrdata[2];
`endif
        end
        3'd1: border_idx <= reg_bus.reg_wrdata[3:0];
`ifdef TEXT_CURSOR_EN
        3'd2: cur_col <= reg_bus.reg_wrdata[6:0];
        3'd3: cur_row <= reg_bus.reg_wrdata[4:0];
`endif
        3'd4: pal_idx <= reg_bus.reg_wrdata[3:0];
        3'd5: pal_lo  <= reg_bus.reg_wrdata;
        3'd6: begin
          palette[pal_idx] <= {reg_bus.reg_wrdata[3:0], pal_lo};
          pal_idx          <= pal_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- frame events ----------------
  // Column mode only switches at the start of vertical blank of line 0, so a
  // frame is never drawn half in one mode and half in the other.
  logic blank_prev, mode80, frame_start;
  assign frame_start = blank && !blank_prev && (vpos == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_prev <= 1'b0;
      mode80     <= 1'b0;
    end else begin
      blank_prev <= blank;
      if (frame_start) mode80 <= ctrl_mode80;
    end
  end

`ifdef TEXT_CURSOR_EN
  logic       vsync_prev;
  logic [4:0] blink_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_prev <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      vsync_prev <= vsync;
      if (vsync && !vsync_prev) blink_cnt <= blink_cnt + 5'd1;
    end
  end
`endif

  // ---------------- stage 0: address generation ----------------
  logic [9:0]         x;
  logic [VPOS_W-1:0]  y;
  logic               active, border, cur_hit;
  logic [6:0]         col;
  logic [4:0]         row;
  logic [2:0]         pix, line;
  logic [VRAM_AW-1:0] row_a, col_a;

  assign active = ({1'b0, hpos} >= H_START) && ({1'b0, hpos} < H_STOP) &&
                  ({1'b0, vpos} >= V_START) && ({1'b0, vpos} < V_STOP);
  assign border = !active && !blank;
  assign x      = 10'(hpos - H_START[HPOS_W-1:0]);
  assign y      = vpos - V_START[VPOS_W-1:0];
  assign row    = 5'(y >> 3);
  assign line   = y[2:0];
  assign row_a  = VRAM_AW'(row);
  assign col_a  = VRAM_AW'(col);

  // NOTE: every always_comb output gets a value on every path (defaults or a
  // full if/else chain) so no latch is inferred.
  always_comb begin
    col = mode80 ? 7'(x >> 3) : 7'(x >> 4);
    pix = mode80 ? 3'(x) : 3'(x >> 1);   // 40-col pixels are 2 clocks wide
    if (!active)     vram_addr = '0;
    else if (mode80) vram_addr = (row_a << 6) + (row_a << 4) + col_a;
    else             vram_addr = (row_a << 5) + (row_a << 3) + col_a;
  end

  // The live col/row never exceed cols-1/ROWS-1, so an out-of-range cursor
  // position simply never matches.
`ifdef TEXT_CURSOR_EN
  assign cur_hit = active && ctrl_cursor && blink_cnt[4] &&
                   (col == cur_col) && (row == cur_row);
`else
  assign cur_hit = 1'b0;
`endif

  // ---------------- stage 1: glyph fetch ----------------
  logic       s1_border, s1_blank, s1_cur, s1_hs, s1_vs;
  logic [2:0] s1_pix, s1_line;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_border <= 1'b0;
      s1_blank  <= 1'b0;
      s1_cur    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_pix    <= '0;
      s1_line   <= '0;
    end else begin
      s1_border <= border;
      s1_blank  <= blank;
      s1_cur    <= cur_hit;
      s1_hs     <= hsync;
      s1_vs     <= vsync;
      s1_pix    <= pix;
      s1_line   <= line;
    end
  end

  assign charram_addr = {vram_rddata[7:0], s1_line};

  // ---------------- stage 2: pixel select and palette ----------------
  logic       s2_border, s2_blank, s2_hs, s2_vs, glyph_bit;
  logic [2:0] s2_pix;
  logic [3:0] s2_fg, s2_bg;
  logic [11:0] colour;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_border <= 1'b0;
      s2_blank  <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_pix    <= '0;
      s2_fg     <= '0;
      s2_bg     <= '0;
    end else begin
      s2_border <= s1_border;
      s2_blank  <= s1_blank;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_pix    <= s1_pix;
      // Cursor cells swap fg/bg for the whole cell.
      s2_fg     <= s1_cur ? vram_rddata[11:8]  : vram_rddata[15:12];
      s2_bg     <= s1_cur ? vram_rddata[15:12] : vram_rddata[11:8];
    end
  end

  always_comb begin
    glyph_bit = charram_data[3'd7 - s2_pix];
    if (s2_blank)                         colour = '0;
    else if (s2_border || !ctrl_text_en)  colour = palette[border_idx];
    else                                  colour = palette[glyph_bit ? s2_fg : s2_bg];
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hsync             <= 1'b0;
      vga_vsync             <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= colour;
      vga_hsync             <= s2_hs;
      vga_vsync             <= s2_vs;
    end
  end

endmodule

// File: tb/tb_text_video_gen2.sv
// Directed self-checking bench for text_video_gen2 (default parameters).
// Models the video RAM and character RAM as one-clock-latency memories.
module tb_text_video_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos;
  logic [8:0]  vpos;
  logic        hsync, vsync, blank;
  logic [10:0] vram_addr;
  logic [15:0] vram_rddata;
  logic [10:0] charram_addr;
  logic [7:0]  charram_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync;

  logic [15:0] vram_mem [0:2047];
  logic [7:0]  char_mem [0:2047];

  int n_checks = 0;
  int n_pass   = 0;

  text_video_gen2_if reg_bus();

  text_video_gen2 dut (
    .clk          (clk),
    .reset        (reset),
    .hpos         (hpos),
    .vpos         (vpos),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank        (blank),
    .reg_bus      (reg_bus),
    .vram_addr    (vram_addr),
    .vram_rddata  (vram_rddata),
    .charram_addr (charram_addr),
    .charram_data (charram_data),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_rddata  <= vram_mem[vram_addr];
    charram_data <= char_mem[charram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int h, input int v, input logic hs, input logic vs, input logic bl);
    hpos  = 10'(h);
    vpos  = 9'(v);
    hsync = hs;
    vsync = vs;
    blank = bl;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    reg_bus.reg_addr   = a;
    reg_bus.reg_wrdata = d;
    reg_bus.reg_wren   = 1'b1;
    tick(1);
    reg_bus.reg_wren   = 1'b0;
  endtask

  // Hold one position until it has crossed the whole pipeline, then compare.
  task automatic pix_check(input string tag, input int h, input int v, input logic bl,
                           input logic [11:0] exp);
    put(h, v, 1'b0, 1'b0, bl);
    tick(3);
    check(tag, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic addr_check(input string tag, input int h, input int v, input int exp);
    put(h, v, 1'b0, 1'b0, 1'b0);
    tick(1);
    check(tag, vram_addr, exp);
  endtask

  task automatic blank_rise(input int v);
    put(0, v, 1'b0, 1'b0, 1'b0);
    tick(1);
    put(0, v, 1'b0, 1'b0, 1'b1);
    tick(1);
    put(0, v, 1'b0, 1'b0, 1'b0);
    tick(1);
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      put(0, 0, 1'b0, 1'b1, 1'b1);
      tick(1);
      put(0, 0, 1'b0, 1'b0, 1'b1);
      tick(1);
    end
  endtask

  // Stream stimulus: first active pixels of the frame in 40-column mode.
  int          st_h  [6] = '{32, 33, 34, 35, 36, 37};
  logic        st_hs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        st_vs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [11:0] st_rgb[6] = '{12'h777, 12'h777, 12'h000, 12'h000, 12'h000, 12'h000};

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram_mem[i] = 16'h0000;
      char_mem[i] = 8'h00;
    end
    vram_mem[0]     = 16'h7041;   // row 0 col 0: fg 7, bg 0, 'A'
    vram_mem[83]    = 16'h9A41;   // row 2 col 3 (40-col): fg 9, bg A, 'A'
    char_mem[11'h208] = 8'h80;    // 'A' line 0: leftmost pixel only

    reg_bus.reg_addr   = 3'd0;
    reg_bus.reg_wrdata = 8'd0;
    reg_bus.reg_wren   = 1'b0;

    // ---- reset state: syncs high at the inputs must not reach the outputs
    reset = 1'b0;
    put(40, 30, 1'b1, 1'b1, 1'b0);
    tick(2);
    check("rst_rgb",   {vga_r, vga_g, vga_b}, 12'h000);
    check("rst_hsync", vga_hsync, 1'b0);
    check("rst_vsync", vga_vsync, 1'b0);
    put(0, 0, 1'b0, 1'b0, 1'b1);
    #1;
    check("rst_vram_addr_blank", vram_addr, 0);
    reset = 1'b1;
    tick(3);

    // ---- first active pixels, 2-clock-wide pixels, 3-clock sync lag
    for (int j = 0; j < 8; j++) begin
      if (j < 6) put(st_h[j], 20, st_hs[j], st_vs[j], 1'b0);
      tick(1);
      if (j >= 2) begin
        check("stream_rgb",   {vga_r, vga_g, vga_b}, st_rgb[j-2]);
        check("stream_hsync", vga_hsync, st_hs[j-2]);
        check("stream_vsync", vga_vsync, st_vs[j-2]);
      end
    end

    // ---- address generation, 40 then 80 columns
    addr_check("a40_r1c0",    32,  28, 40);
    addr_check("a40_r1c5",    112, 28, 45);
    addr_check("a40_last",    671, 219, 999);
    addr_check("a_right_out", 672, 28, 0);
    addr_check("a_below_out", 32,  220, 0);
    reg_write(3'd0, 8'h03);
    addr_check("a_midframe_still40", 32, 28, 40);
    blank_rise(0);
    addr_check("a80_r1c0", 32,  28, 80);
    addr_check("a80_r1c5", 72,  28, 85);
    addr_check("a80_last", 671, 219, 1999);
    reg_write(3'd0, 8'h02);
    blank_rise(7);
    addr_check("a_blank_not_line0", 32, 28, 80);
    blank_rise(0);
    addr_check("a40_again_r1c0", 32, 28, 40);

    // ---- border colour with text disabled
    reg_write(3'd1, 8'h05);
    reg_write(3'd0, 8'h00);
    pix_check("border_active_area", 32, 20, 1'b0, 12'h555);
    pix_check("border_area",        5, 100, 1'b0, 12'h555);
    pix_check("border_blank",       32, 20, 1'b1, 12'h000);

    // ---- palette programming with index wrap
    reg_write(3'd4, 8'h0F);
    reg_write(3'd5, 8'h34);
    reg_write(3'd6, 8'h02);
    reg_write(3'd5, 8'h56);
    reg_write(3'd6, 8'h01);
    reg_write(3'd1, 8'h0F);
    pix_check("pal15", 5, 100, 1'b0, 12'h234);
    reg_write(3'd1, 8'h00);
    pix_check("pal0_after_wrap", 5, 100, 1'b0, 12'h156);
    reg_write(3'd1, 8'h0E);
    pix_check("pal14_untouched", 5, 100, 1'b0, 12'hEEE);
    reg_write(3'd7, 8'hFF);
    pix_check("reg7_ignored", 5, 100, 1'b0, 12'hEEE);
    reg_write(3'd0, 8'h02);

    // ---- cursor at row 2 col 3 (one vsync edge already seen in the stream)
    reg_write(3'd2, 8'd3);
    reg_write(3'd3, 8'd2);
    reg_write(3'd0, 8'h06);
`ifdef TEXT_CURSOR_EN
    pix_check("cur_phase0_normal", 80, 36, 1'b0, 12'h999);
    vsync_pulses(16);
    pix_check("cur_phase1_inverted", 80, 36, 1'b0, 12'hAAA);
    reg_write(3'd2, 8'd50);
    pix_check("cur_col50_no_invert", 80, 36, 1'b0, 12'h999);
    reg_write(3'd2, 8'd3);
    pix_check("cur_back_inverted", 80, 36, 1'b0, 12'hAAA);
    vsync_pulses(16);
    pix_check("cur_wrap_normal", 80, 36, 1'b0, 12'h999);
`else
    pix_check("nocur_normal_a", 80, 36, 1'b0, 12'h999);
    vsync_pulses(16);
    pix_check("nocur_normal_b", 80, 36, 1'b0, 12'h999);
`endif

    // ---- reset mid-line
    reg_write(3'd0, 8'h00);
    reg_write(3'd1, 8'h0F);
    put(200, 50, 1'b1, 1'b0, 1'b0);
    tick(3);
    check("pre_reset_rgb", {vga_r, vga_g, vga_b}, 12'h234);
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_rgb",   {vga_r, vga_g, vga_b}, 12'h000);
    check("reset_async_hsync", vga_hsync, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(2);
    check("release_hsync_t2", vga_hsync, 1'b0);
    tick(1);
    check("release_hsync_t3", vga_hsync, 1'b1);
    reg_write(3'd0, 8'h00);
    reg_write(3'd1, 8'h0F);
    pix_check("post_reset_pal15", 5, 100, 1'b0, 12'hFFF);
    reg_write(3'd1, 8'h00);
    pix_check("post_reset_pal0", 5, 100, 1'b0, 12'h000);
    reg_write(3'd1, 8'h05);
    pix_check("post_reset_pal5", 5, 100, 1'b0, 12'h555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
